// File: rtl/ram_req_pkg.sv
// Shared types and defaults for the RAMsim request initiator.
//   chan_state_e  : per-channel lifecycle IDLE -> REQ -> WAIT -> RSP
//   chan_result_t : completion record (timeout flag + read data) at default width
//   timer_width() : bits needed for a timeout counter that reaches cyc-1
package ram_req_pkg;

    localparam int DEF_ADDR_W      = 64;
    localparam int DEF_DATA_W      = 64;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } chan_state_e;

    typedef struct packed {
        logic                  timeout;
        logic [DEF_DATA_W-1:0] rdata;
    } chan_result_t;

    function automatic int timer_width(input int cyc);
        return (cyc > 2) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/ram_req_chan.sv
// One request channel (read or write) towards the memory model.
// Holds a single outstanding operation: latches the command, drives the
// valid/addr/data request until the model takes it, waits for the fin
// pulse (or a timeout) and then parks the result until the top releases it.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   accept             command for this channel accepted this cycle
//   cmd_addr/cmd_wdata command payload latched on accept
//   xvalid/xaddr/xdata request to the model
//   xready/xfin        model handshake and completion pulse
//   rdata              model read data, valid with xfin
//   idle/busy/done     channel in IDLE / in REQ or WAIT / in RSP
//   res_timeout/res_rdata  parked result while done
//   release_rsp        result consumed by the host, return to IDLE
module ram_req_chan
    import ram_req_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter bit IS_WRITE    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              xvalid,
    output logic [ADDR_W-1:0] xaddr,
    output logic [DATA_W-1:0] xdata,
    input  logic              xready,
    input  logic              xfin,
    input  logic [DATA_W-1:0] rdata,
    output logic              idle,
    output logic              busy,
    output logic              done,
    output logic              res_timeout,
    output logic [DATA_W-1:0] res_rdata,
    input  logic              release_rsp
);

    localparam int TW = timer_width(TIMEOUT_CYC);
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

    chan_state_e       state_reg;
    logic              valid_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              timeout_reg;
    logic [TW-1:0]     timer_reg;
    logic              expired;
    logic [DATA_W-1:0] cap_data;

    // Write completions carry no data.
    assign cap_data = IS_WRITE ? '0 : rdata;
    // Last permitted cycle in REQ/WAIT; a fin in this same cycle still wins.
    assign expired  = (TIMEOUT_CYC != 0) && (timer_reg == TIMER_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            valid_reg   <= 1'b0;
            addr_reg    <= '0;
            data_reg    <= '0;
            rdata_reg   <= '0;
            timeout_reg <= 1'b0;
            timer_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg  <= cmd_addr;
                        data_reg  <= cmd_wdata;
                        timer_reg <= '0;
                        valid_reg <= 1'b1;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (xready && xfin) begin
                        // Model took the request and finished in the same cycle.
                        valid_reg   <= 1'b0;
                        timeout_reg <= 1'b0;
                        rdata_reg   <= cap_data;
                        state_reg   <= RSP;
                    end else if (expired) begin
                        valid_reg   <= 1'b0;
                        timeout_reg <= 1'b1;
                        rdata_reg   <= '0;
                        state_reg   <= RSP;
                    end else if (xready) begin
                        valid_reg <= 1'b0;
                        timer_reg <= timer_reg + 1'b1;
                        state_reg <= WAIT;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                WAIT: begin
                    if (xfin) begin
                        timeout_reg <= 1'b0;
                        rdata_reg   <= cap_data;
                        state_reg   <= RSP;
                    end else if (expired) begin
                        timeout_reg <= 1'b1;
                        rdata_reg   <= '0;
                        state_reg   <= RSP;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                RSP: begin
                    if (release_rsp) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign xvalid      = valid_reg;
    assign xaddr       = addr_reg;
    assign xdata       = data_reg;
    assign idle        = (state_reg == IDLE);
    assign busy        = (state_reg == REQ) || (state_reg == WAIT);
    assign done        = (state_reg == RSP);
    assign res_timeout = timeout_reg;
    assign res_rdata   = rdata_reg;

endmodule

// File: rtl/ram_req_initiator.sv
// Request-side master for the RAMsim_DPI memory model.
// Splits a single host command stream into independent read and write
// channels (one outstanding op each) and merges their completions back
// into one registered response port with round-robin arbitration.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata   host command
//   rsp_valid/rsp_ready/rsp_write/rsp_timeout/rsp_rdata host response
//   stray_fin                         sticky: fin seen on a channel not expecting one
//   rvalid/raddr, readReady, readfin, rdata            model read channel
//   wvalid/waddr/wdata, writeReady, writefin           model write channel
module ram_req_initiator
    import ram_req_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic              rsp_timeout,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              stray_fin,
    output logic              rvalid,
    output logic [ADDR_W-1:0] raddr,
    output logic              wvalid,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    input  logic              readReady,
    input  logic              writeReady,
    input  logic              readfin,
    input  logic              writefin,
    input  logic [DATA_W-1:0] rdata
);

    logic              run_reg;
    logic              rsp_valid_reg;
    logic              rsp_write_reg;
    logic              rsp_timeout_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              prio_wr_reg;
    logic              stray_reg;

    logic              rd_idle, rd_busy, rd_done, rd_timeout;
    logic              wr_idle, wr_busy, wr_done, wr_timeout;
    logic [DATA_W-1:0] rd_rdata, wr_rdata, rd_wdata_unused;
    logic              rd_accept, wr_accept, rd_release, wr_release;
    logic              rsp_fire, slot_free, rd_elig, wr_elig, grant_rd, grant_wr;

    // run_reg keeps cmd_ready low while in reset and for the first edge after it.
    assign cmd_ready = run_reg && (cmd_write ? wr_idle : rd_idle);
    assign rd_accept = cmd_valid && cmd_ready && !cmd_write;
    assign wr_accept = cmd_valid && cmd_ready && cmd_write;

    // rsp_write_reg doubles as the owner tag of the response register; the
    // owning channel stays in RSP until the host actually takes the response.
    assign rsp_fire   = rsp_valid_reg && rsp_ready;
    assign rd_release = rsp_fire && !rsp_write_reg;
    assign wr_release = rsp_fire && rsp_write_reg;

    assign slot_free = !rsp_valid_reg || rsp_ready;
    assign rd_elig   = rd_done && !(rsp_valid_reg && !rsp_write_reg);
    assign wr_elig   = wr_done && !(rsp_valid_reg && rsp_write_reg);
    assign grant_wr  = slot_free && wr_elig && (!rd_elig || prio_wr_reg);
    assign grant_rd  = slot_free && rd_elig && (!wr_elig || !prio_wr_reg);

    ram_req_chan #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC), .IS_WRITE(1'b0)
    ) u_rd_chan (
        .clk(clk), .rst_n(rst_n), .accept(rd_accept),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .xvalid(rvalid), .xaddr(raddr), .xdata(rd_wdata_unused),
        .xready(readReady), .xfin(readfin), .rdata(rdata),
        .idle(rd_idle), .busy(rd_busy), .done(rd_done),
        .res_timeout(rd_timeout), .res_rdata(rd_rdata), .release_rsp(rd_release)
    );

    ram_req_chan #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC), .IS_WRITE(1'b1)
    ) u_wr_chan (
        .clk(clk), .rst_n(rst_n), .accept(wr_accept),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .xvalid(wvalid), .xaddr(waddr), .xdata(wdata),
        .xready(writeReady), .xfin(writefin), .rdata(rdata),
        .idle(wr_idle), .busy(wr_busy), .done(wr_done),
        .res_timeout(wr_timeout), .res_rdata(wr_rdata), .release_rsp(wr_release)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg         <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_write_reg   <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            rsp_rdata_reg   <= '0;
            prio_wr_reg     <= 1'b1;
            stray_reg       <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            if (grant_wr) begin
                rsp_valid_reg   <= 1'b1;
                rsp_write_reg   <= 1'b1;
                rsp_timeout_reg <= wr_timeout;
                rsp_rdata_reg   <= wr_rdata;
                prio_wr_reg     <= 1'b0;
            end else if (grant_rd) begin
                rsp_valid_reg   <= 1'b1;
                rsp_write_reg   <= 1'b0;
                rsp_timeout_reg <= rd_timeout;
                rsp_rdata_reg   <= rd_rdata;
                prio_wr_reg     <= 1'b1;
            end else if (rsp_fire) begin
                rsp_valid_reg <= 1'b0;
            end
            // A fin outside REQ/WAIT belongs to no live op (e.g. after a timeout).
            if ((readfin && !rd_busy) || (writefin && !wr_busy)) begin
                stray_reg <= 1'b1;
            end
        end
    end

    assign rsp_valid   = rsp_valid_reg;
    assign rsp_write   = rsp_write_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign stray_fin   = stray_reg;

endmodule

// File: tb/tb_ram_req_initiator.sv
module tb_ram_req_initiator;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_ready = 1'b1;
    logic          readReady = 1'b0, writeReady = 1'b0, readfin = 1'b0, writefin = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          cmd_ready, rsp_valid, rsp_write, rsp_timeout, stray_fin, rvalid, wvalid;
    logic [DW-1:0] rsp_rdata, wdata;
    logic [AW-1:0] raddr, waddr;

    always #5 clk = ~clk;

    ram_req_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_timeout(rsp_timeout), .rsp_rdata(rsp_rdata), .stray_fin(stray_fin),
        .rvalid(rvalid), .raddr(raddr), .wvalid(wvalid), .waddr(waddr), .wdata(wdata),
        .readReady(readReady), .writeReady(writeReady),
        .readfin(readfin), .writefin(writefin), .rdata(rdata)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_expired(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // ---------------- behavioural model (index 0 = read, 1 = write) ----------------
    bit          m_run;
    bit          m_has[2], m_hs[2], m_fin[2], m_to[2];
    int          m_age[2];
    logic [63:0] m_addr[2], m_data[2], m_rdat[2];
    bit          o_valid, o_write, o_to, last_wr, m_stray;
    logic [63:0] o_rdata;

    task automatic model_reset();
        m_run = 0; o_valid = 0; o_write = 0; o_to = 0; o_rdata = '0;
        last_wr = 0; m_stray = 0;
        for (int c = 0; c < 2; c++) begin
            m_has[c] = 0; m_hs[c] = 0; m_fin[c] = 0; m_to[c] = 0; m_age[c] = 0;
            m_addr[c] = '0; m_data[c] = '0; m_rdat[c] = '0;
        end
    endtask

    task automatic model_step();
        bit rdy_in[2], fin_in[2], elig[2];
        bit fire, owner, cmd_ok;
        int pick;
        rdy_in[0] = readReady;  rdy_in[1] = writeReady;
        fin_in[0] = readfin;    fin_in[1] = writefin;
        cmd_ok = m_run && !m_has[cmd_write];
        fire   = o_valid && rsp_ready;
        owner  = o_write;
        // response port: an op is offered once finished and not already presented
        for (int c = 0; c < 2; c++)
            elig[c] = m_has[c] && m_fin[c] && !(o_valid && (int'(o_write) == c));
        if (!o_valid || rsp_ready) begin
            pick = -1;
            if (elig[0] && elig[1]) pick = last_wr ? 0 : 1;
            else if (elig[1])       pick = 1;
            else if (elig[0])       pick = 0;
            if (pick >= 0) begin
                o_valid = 1; o_write = (pick == 1); o_to = m_to[pick]; o_rdata = m_rdat[pick];
                last_wr = (pick == 1);
            end else begin
                o_valid = 0;
            end
        end
        // per-channel op progress
        for (int c = 0; c < 2; c++) begin
            if (fin_in[c] && !(m_has[c] && !m_fin[c])) m_stray = 1;
            if (m_has[c] && !m_fin[c]) begin
                if (fin_in[c] && (m_hs[c] || rdy_in[c])) begin
                    m_fin[c] = 1; m_to[c] = 0; m_rdat[c] = (c == 0) ? rdata : '0;
                end else if (m_age[c] == TO - 1) begin
                    m_fin[c] = 1; m_to[c] = 1; m_rdat[c] = '0;
                end else begin
                    if (rdy_in[c]) m_hs[c] = 1;
                    m_age[c]++;
                end
            end
        end
        if (fire) m_has[owner] = 0;
        if (cmd_valid && cmd_ok) begin
            m_has[cmd_write] = 1; m_hs[cmd_write] = 0; m_fin[cmd_write] = 0; m_age[cmd_write] = 0;
            m_addr[cmd_write] = cmd_addr; m_data[cmd_write] = cmd_wdata;
        end
        m_run = 1;
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
    end

    // compare process: every falling edge
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            model_reset();
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_rvalid", rvalid, 0);
            chk("rst_wvalid", wvalid, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_stray", stray_fin, 0);
        end else begin
            chk("cmd_ready", cmd_ready, m_run && !m_has[cmd_write]);
            chk("rvalid", rvalid, m_has[0] && !m_hs[0] && !m_fin[0]);
            if (m_has[0] && !m_hs[0] && !m_fin[0]) chk("raddr", raddr, m_addr[0]);
            chk("wvalid", wvalid, m_has[1] && !m_hs[1] && !m_fin[1]);
            if (m_has[1] && !m_hs[1] && !m_fin[1]) begin
                chk("waddr", waddr, m_addr[1]);
                chk("wdata", wdata, m_data[1]);
            end
            chk("rsp_valid", rsp_valid, o_valid);
            if (o_valid) begin
                chk("rsp_write", rsp_write, o_write);
                chk("rsp_timeout", rsp_timeout, o_to);
                chk("rsp_rdata", rsp_rdata, o_rdata);
            end
            chk("stray_fin", stray_fin, m_stray);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit wr, input logic [63:0] a, input logic [63:0] d);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        #1;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                tick();
                cmd_valid = 0;
                return;
            end
            tick();
        end
        cmd_valid = 0;
        bound_expired("issue_accept");
    endtask

    task automatic wait_rsp(input string name);
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid) return;
            tick();
        end
        bound_expired(name);
    endtask

    int cnt;

    initial begin
        #2;
        chk("t0_cmd_ready", cmd_ready, 0);
        chk("t0_rsp_valid", rsp_valid, 0);
        chk("t0_raddr", raddr, 0);
        tick(); tick();
        rst_n = 1;
        tick();

        // 1: write, fin one cycle after handshake
        writeReady = 1;
        issue(1, 64'h100, 64'hDEADBEEF);
        chk("t1_wvalid", wvalid, 1);
        chk("t1_waddr", waddr, 64'h100);
        chk("t1_wdata", wdata, 64'hDEADBEEF);
        tick();
        writefin = 1; tick(); writefin = 0;
        wait_rsp("t1_rsp");
        chk("t1_rsp_write", rsp_write, 1);
        chk("t1_rsp_timeout", rsp_timeout, 0);
        tick();

        // 2: read with readReady low 5 cycles, fin later
        readReady = 0;
        issue(0, 64'h100, 0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (rvalid) cnt++;
            chk("t2_raddr", raddr, 64'h100);
            tick();
        end
        readReady = 1;
        if (rvalid) cnt++;
        tick();
        readReady = 0;
        chk("t2_rvalid_cycles", cnt, 6);
        chk("t2_rvalid_dropped", rvalid, 0);
        tick(); tick();
        readfin = 1; rdata = 64'hDEADBEEF; tick(); readfin = 0; rdata = '0;
        wait_rsp("t2_rsp");
        chk("t2_rsp_write", rsp_write, 0);
        chk("t2_rsp_rdata", rsp_rdata, 64'hDEADBEEF);
        tick();

        // 3: fin coincident with handshake
        issue(0, 64'h200, 0);
        readReady = 1; readfin = 1; rdata = 64'h55; tick();
        readReady = 0; readfin = 0; rdata = '0;
        wait_rsp("t3_rsp");
        chk("t3_rsp_rdata", rsp_rdata, 64'h55);
        chk("t3_stray", stray_fin, 0);
        tick();

        // 4: timeout, then a late fin
        issue(0, 64'h300, 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!rvalid) break;
            cnt++;
            tick();
        end
        chk("t4_rvalid_cycles", cnt, TO);
        wait_rsp("t4_rsp");
        chk("t4_rsp_timeout", rsp_timeout, 1);
        chk("t4_rsp_rdata", rsp_rdata, 0);
        tick();
        readfin = 1; tick(); readfin = 0;
        chk("t4_stray", stray_fin, 1);

        // 5: simultaneous completion, write first after reset-order priority
        issue(1, 64'h500, 64'h1111);
        issue(0, 64'h600, 0);
        readReady = 1; writeReady = 1; readfin = 1; writefin = 1; rdata = 64'hA5;
        tick();
        readReady = 0; writeReady = 0; readfin = 0; writefin = 0; rdata = '0;
        wait_rsp("t5a_rsp");
        chk("t5a_first_write", rsp_write, 1);
        tick();
        chk("t5a_second_valid", rsp_valid, 1);
        chk("t5a_second_read", rsp_write, 0);
        chk("t5a_second_rdata", rsp_rdata, 64'hA5);
        tick();
        // lone write moves priority to the read channel
        writeReady = 1;
        issue(1, 64'h700, 64'h2222);
        writefin = 1; tick(); writefin = 0; writeReady = 0;
        wait_rsp("t5b_rsp");
        chk("t5b_write", rsp_write, 1);
        tick();
        // second pair with a stalled host
        rsp_ready = 0;
        issue(1, 64'h800, 64'h3333);
        issue(0, 64'h900, 0);
        readReady = 1; writeReady = 1; readfin = 1; writefin = 1; rdata = 64'h77;
        tick();
        readReady = 0; writeReady = 0; readfin = 0; writefin = 0; rdata = '0;
        wait_rsp("t5c_rsp");
        for (int i = 0; i < 4; i++) begin
            chk("t5c_hold_valid", rsp_valid, 1);
            chk("t5c_hold_read", rsp_write, 0);
            chk("t5c_hold_rdata", rsp_rdata, 64'h77);
            cmd_write = 0; #1;
            chk("t5c_rd_ready", cmd_ready, 0);
            cmd_write = 1; #1;
            chk("t5c_wr_ready", cmd_ready, 0);
            tick();
        end
        rsp_ready = 1;
        chk("t5c_read_first", rsp_write, 0);
        tick();
        chk("t5c_then_valid", rsp_valid, 1);
        chk("t5c_then_write", rsp_write, 1);
        tick();

        // 6: reset while waiting for fin
        writeReady = 1;
        issue(1, 64'hA00, 64'h4444);
        tick();
        #2;
        rst_n = 0;
        #1;
        chk("t6_cmd_ready", cmd_ready, 0);
        chk("t6_wvalid", wvalid, 0);
        chk("t6_waddr", waddr, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_stray", stray_fin, 0);
        tick(); tick();
        rst_n = 1;
        issue(1, 64'hB00, 64'h5555);
        chk("t6_new_waddr", waddr, 64'hB00);
        writefin = 1; tick(); writefin = 0;
        wait_rsp("t6_rsp");
        chk("t6_rsp_write", rsp_write, 1);
        chk("t6_rsp_timeout", rsp_timeout, 0);
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
